// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the fetch PC, steering it from the BTB, EX-stage redirects, stalls and halt,
// and keeps saturating branch/mispredict counters.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btb_hit,
  input  logic [15:0]      btb_target,
  input  logic             stall_IF,
  input  logic             hlt_ID,
  input  logic             br_instr_ID_EX,
  input  logic             flow_change_ID_EX,
  input  logic             btb_hit_ID_EX,
  input  logic [15:0]      pred_tgt_ID_EX,
  input  logic [15:0]      dst_ID_EX,
  input  logic [15:0]      pc_ID_EX,
  output logic [15:0]      PC,
  output logic [15:0]      pc_inc_IF,
  output logic             pred_taken_IF,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  typedef enum logic [1:0] {RESET_FETCH, RUN, HALT} state_t;
  state_t           r_state, w_next_state;
  logic [15:0]      r_pc, w_next_pc, w_redirect;
  logic             w_mispredict;
  logic [CNT_W-1:0] r_br_cnt, r_mispred_cnt;
  always_comb begin
    w_mispredict = br_instr_ID_EX & ((btb_hit_ID_EX ^ flow_change_ID_EX) |
                   (btb_hit_ID_EX & flow_change_ID_EX & (pred_tgt_ID_EX != dst_ID_EX)));
    w_redirect   = (btb_hit_ID_EX & ~flow_change_ID_EX) ? pc_ID_EX : dst_ID_EX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= RESET_FETCH;
    else     r_state <= w_next_state;
  // HALT only leaves on a redirect from an older branch; RESET_FETCH always moves on to RUN
  always_comb begin
    w_next_state = (r_state == HALT) ? (w_mispredict ? RUN : HALT) :
                   (r_state == RUN && hlt_ID && !w_mispredict && !stall_IF) ? HALT : RUN;
  end
  always_comb begin
    pc_inc_IF     = r_pc + 16'd1;
    pred_taken_IF = (r_state == RUN) & btb_hit;
    flush         = w_mispredict & ~rst;
    halted        = (r_state == HALT);
    w_next_pc     = w_mispredict ? w_redirect :
                    (halted | hlt_ID | stall_IF) ? r_pc :
                    pred_taken_IF ? btb_target : pc_inc_IF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc          <= RESET_PC;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (br_instr_ID_EX && !(&r_br_cnt)) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_mispredict && !(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  assign PC          = r_pc;
  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized traffic against a behavioural fetch-PC model.
module tb_pc_fetch_ctrl;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  logic          clk = 0, rst = 1;
  logic          btb_hit = 0, stall_IF = 0, hlt_ID = 0;
  logic          br_instr_ID_EX = 0, flow_change_ID_EX = 0, btb_hit_ID_EX = 0;
  logic [15:0]   btb_target = 0, pred_tgt_ID_EX = 0, dst_ID_EX = 0, pc_ID_EX = 0;
  logic [15:0]   PC, pc_inc_IF;
  logic          pred_taken_IF, flush, halted;
  logic [CW-1:0] br_cnt, mispred_cnt;
  int vectors = 0, miscompares = 0;
  int m_pc, m_br, m_mis;
  bit m_halt, m_rf;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(16'h0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btb_hit(btb_hit), .btb_target(btb_target), .stall_IF(stall_IF),
    .hlt_ID(hlt_ID), .br_instr_ID_EX(br_instr_ID_EX), .flow_change_ID_EX(flow_change_ID_EX),
    .btb_hit_ID_EX(btb_hit_ID_EX), .pred_tgt_ID_EX(pred_tgt_ID_EX), .dst_ID_EX(dst_ID_EX),
    .pc_ID_EX(pc_ID_EX), .PC(PC), .pc_inc_IF(pc_inc_IF), .pred_taken_IF(pred_taken_IF),
    .flush(flush), .halted(halted), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt));

  function automatic bit mis_f();
    return br_instr_ID_EX && ((btb_hit_ID_EX != flow_change_ID_EX) ||
           (btb_hit_ID_EX && flow_change_ID_EX && pred_tgt_ID_EX != dst_ID_EX));
  endfunction

  task automatic clear_inputs();
    btb_hit = 0; stall_IF = 0; hlt_ID = 0; br_instr_ID_EX = 0; flow_change_ID_EX = 0;
    btb_hit_ID_EX = 0; btb_target = 0; pred_tgt_ID_EX = 0; dst_ID_EX = 0; pc_ID_EX = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m_pc = 0; m_br = 0; m_mis = 0; m_halt = 0; m_rf = 1;
  endtask

  task automatic tick();
    bit mis = mis_f();
    int npc;
    bit nh;
    if (mis) npc = (btb_hit_ID_EX && !flow_change_ID_EX) ? int'(pc_ID_EX) : int'(dst_ID_EX);
    else if (m_halt || hlt_ID || stall_IF) npc = m_pc;
    else if (btb_hit && !m_rf) npc = int'(btb_target);
    else npc = (m_pc + 1) % 65536;
    nh = m_halt ? !mis : (!m_rf && hlt_ID && !mis && !stall_IF);
    if (br_instr_ID_EX && m_br < SAT) m_br++;
    if (mis && m_mis < SAT) m_mis++;
    @(posedge clk); #1;
    m_pc = npc; m_halt = nh; m_rf = 0;
  endtask

  task automatic mispredict_b(input logic [15:0] dst);
    br_instr_ID_EX = 1; btb_hit_ID_EX = 0; flow_change_ID_EX = 1; dst_ID_EX = dst;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (PC !== 16'h0000 || flush !== 0 || halted !== 0 || pred_taken_IF !== 0 || br_cnt !== 0 || mispred_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_state: PC=%h flush=%b halted=%b pt=%b br=%0d mis=%0d, want 0000/0/0/0/0/0",
               PC, flush, halted, pred_taken_IF, br_cnt, mispred_cnt);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (PC !== 16'(i) || flush !== 0 || br_cnt !== 0 || mispred_cnt !== 0) begin
        miscompares++;
        $display("FAIL reset_seq: PC=%h flush=%b br=%0d mis=%0d, want PC=%h flush=0 cnt=0", PC, flush, br_cnt, mispred_cnt, 16'(i));
      end
    end
  endtask

  task automatic test_btb();
    do_reset();
    btb_hit = 1; btb_target = 16'h0040; #1;
    vectors++;
    if (pred_taken_IF !== 0) begin miscompares++; $display("FAIL btb_rf_pt: got %b want 0", pred_taken_IF); end
    tick();
    vectors++;
    if (PC !== 16'h0001) begin miscompares++; $display("FAIL btb_rf_ignore: PC=%h want 0001", PC); end
    btb_hit = 0;
    repeat (4) tick();
    btb_hit = 1; #1;
    vectors++;
    if (PC !== 16'h0005 || pred_taken_IF !== 1) begin
      miscompares++; $display("FAIL btb_run_pt: PC=%h pt=%b want 0005/1", PC, pred_taken_IF);
    end
    tick();
    btb_hit = 0;
    vectors++;
    if (PC !== 16'h0040) begin miscompares++; $display("FAIL btb_taken: PC=%h want 0040", PC); end
  endtask

  task automatic test_mispredict();
    int br0, mis0;
    br0 = m_br; mis0 = m_mis;
    br_instr_ID_EX = 1; btb_hit_ID_EX = 1; flow_change_ID_EX = 0; pc_ID_EX = 16'h0011; stall_IF = 1; #1;
    vectors++;
    if (flush !== 1) begin miscompares++; $display("FAIL mis_a_flush: got %b want 1", flush); end
    tick();
    clear_inputs();
    vectors++;
    if (PC !== 16'h0011 || int'(br_cnt) !== br0 + 1 || int'(mispred_cnt) !== mis0 + 1) begin
      miscompares++;
      $display("FAIL mis_a: PC=%h br=%0d mis=%0d want 0011/%0d/%0d", PC, br_cnt, mispred_cnt, br0 + 1, mis0 + 1);
    end
    br_instr_ID_EX = 1; btb_hit_ID_EX = 1; flow_change_ID_EX = 1; pred_tgt_ID_EX = 16'h0020; dst_ID_EX = 16'h0030; #1;
    vectors++;
    if (flush !== 1) begin miscompares++; $display("FAIL mis_c_flush: got %b want 1", flush); end
    tick();
    vectors++;
    if (PC !== 16'h0030) begin miscompares++; $display("FAIL mis_c: PC=%h want 0030", PC); end
    br0 = m_br; mis0 = m_mis;
    pred_tgt_ID_EX = 16'h0030; #1;
    vectors++;
    if (flush !== 0) begin miscompares++; $display("FAIL match_flush: got %b want 0", flush); end
    tick();
    clear_inputs();
    vectors++;
    if (PC !== 16'h0031 || int'(br_cnt) !== br0 + 1 || int'(mispred_cnt) !== mis0) begin
      miscompares++;
      $display("FAIL match: PC=%h br=%0d mis=%0d want 0031/%0d/%0d", PC, br_cnt, mispred_cnt, br0 + 1, mis0);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    mispredict_b(16'h0008);
    tick();
    clear_inputs();
    hlt_ID = 1;
    tick();
    hlt_ID = 0;
    vectors++;
    if (PC !== 16'h0008 || halted !== 1) begin
      miscompares++; $display("FAIL halt_enter: PC=%h halted=%b want 0008/1", PC, halted);
    end
    for (int i = 0; i < 4; i++) begin
      btb_hit = i[0]; stall_IF = i[1]; btb_target = 16'h0077;
      tick();
      vectors++;
      if (PC !== 16'h0008 || halted !== 1 || pred_taken_IF !== 0) begin
        miscompares++; $display("FAIL halt_hold: PC=%h halted=%b pt=%b want 0008/1/0", PC, halted, pred_taken_IF);
      end
    end
    clear_inputs();
    mispredict_b(16'h0100); #1;
    vectors++;
    if (flush !== 1) begin miscompares++; $display("FAIL halt_exit_flush: got %b want 1", flush); end
    tick();
    clear_inputs();
    vectors++;
    if (PC !== 16'h0100 || halted !== 0) begin
      miscompares++; $display("FAIL halt_exit: PC=%h halted=%b want 0100/0", PC, halted);
    end
    tick();
    vectors++;
    if (PC !== 16'h0101) begin miscompares++; $display("FAIL halt_run: PC=%h want 0101", PC); end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    tick();
    mispredict_b(16'hFFFF);
    tick();
    clear_inputs();
    vectors++;
    if (PC !== 16'hFFFF || pc_inc_IF !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_inc: PC=%h inc=%h want FFFF/0000", PC, pc_inc_IF);
    end
    tick();
    vectors++;
    if (PC !== 16'h0000) begin miscompares++; $display("FAIL wrap: PC=%h want 0000", PC); end
    for (int i = 0; i < SAT + 3; i++) begin
      mispredict_b(16'(i));
      tick();
      vectors++;
      if (int'(mispred_cnt) !== m_mis || int'(br_cnt) !== m_br) begin
        miscompares++; $display("FAIL saturate: mis=%0d br=%0d want %0d/%0d", mispred_cnt, br_cnt, m_mis, m_br);
      end
    end
    vectors++;
    if (int'(mispred_cnt) !== SAT) begin miscompares++; $display("FAIL sat_final: mis=%0d want %0d", mispred_cnt, SAT); end
    btb_hit_ID_EX = 1; flow_change_ID_EX = 0; pc_ID_EX = 16'h1234;
    #2 rst = 1;
    #1;
    vectors++;
    if (PC !== 16'h0000 || flush !== 0 || halted !== 0 || pred_taken_IF !== 0 || br_cnt !== 0 || mispred_cnt !== 0) begin
      miscompares++;
      $display("FAIL async_rst: PC=%h flush=%b halted=%b pt=%b br=%0d mis=%0d want all 0", PC, flush, halted, pred_taken_IF, br_cnt, mispred_cnt);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) do_reset();
      btb_hit           = ($urandom_range(0, 2) == 0);
      btb_target        = 16'($urandom);
      stall_IF          = ($urandom_range(0, 4) == 0);
      hlt_ID            = ($urandom_range(0, 15) == 0);
      br_instr_ID_EX    = ($urandom_range(0, 2) == 0);
      flow_change_ID_EX = 1'($urandom);
      btb_hit_ID_EX     = 1'($urandom);
      pred_tgt_ID_EX    = 16'($urandom_range(0, 3));
      dst_ID_EX         = 16'($urandom_range(0, 3));
      pc_ID_EX          = 16'($urandom);
      #1;
      vectors++;
      if (PC !== 16'(m_pc) || pc_inc_IF !== 16'(m_pc + 1) || flush !== mis_f() || halted !== m_halt ||
          pred_taken_IF !== (btb_hit && !m_rf && !m_halt) || int'(br_cnt) !== m_br || int'(mispred_cnt) !== m_mis) begin
        miscompares++;
        $display("FAIL random[%0d]: PC=%h inc=%h flush=%b halted=%b pt=%b br=%0d mis=%0d want PC=%h halted=%b br=%0d mis=%0d",
                 n, PC, pc_inc_IF, flush, halted, pred_taken_IF, br_cnt, mispred_cnt, 16'(m_pc), m_halt, m_br, m_mis);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_btb();
    test_mispredict();
    test_halt();
    test_wrap_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
